// File: rtl/prod_accum.sv
// Accumulates LEN unsigned 16-bit products into a 24-bit sum, presenting the
// result with a valid/ready handshake; flush closes a non-empty run early.
module prod_accum #(
    parameter int LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] prod,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [23:0] acc,
    output logic [8:0]  cnt,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t      state_q, state_d;
    logic [23:0] acc_q, acc_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        accept;
    logic        last_prod;

    assign accept    = (state_q == ST_ACC) && in_valid;
    assign last_prod = (cnt_q == 9'(LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // An empty run never produces a result, so flush needs a product either
    // already counted or arriving this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: begin
                if (accept && (last_prod || flush))
                    state_d = ST_HOLD;
                else if (flush && (cnt_q != '0))
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready)
                    state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept) begin
            acc_d = acc_q + {8'd0, prod};
            cnt_d = cnt_q + 9'd1;
        end else if ((state_q == ST_HOLD) && out_ready) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC) && !rst;
        out_valid = (state_q == ST_HOLD);
        acc       = acc_q;
        cnt       = cnt_q;
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: four instances (LEN = 8, 4, 1, 256) share
// clock and reset; each scenario drives one instance and checks hand values.
module tb_prod_accum;

    localparam int NDUT = 4;
    localparam int LENS [NDUT] = '{8, 4, 1, 256};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] prod      [NDUT];
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic        flush     [NDUT];
    logic [23:0] acc       [NDUT];
    logic [8:0]  cnt       [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        prod_accum #(.LEN(LENS[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .prod      (prod[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .flush     (flush[g]),
            .acc       (acc[g]),
            .cnt       (cnt[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] p, input logic f);
        in_valid[i] = v;
        prod[i]     = p;
        flush[i]    = f;
    endtask

    task automatic idle(input int i);
        drive(i, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic feed(input int i, input int n, input logic [15:0] p);
        for (int k = 0; k < n; k++) begin
            drive(i, 1'b1, p, 1'b0);
            step();
        end
        idle(i);
    endtask

    task automatic release_result(input int i);
        out_ready[i] = 1'b1;
        step();
        out_ready[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            idle(i);
            out_ready[i] = 1'b0;
        end

        // Reset held: no acceptance allowed.
        step();
        step();
        check("rst_in_ready", 32'(in_ready[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("post_rst_acc", 32'(acc[0]), 32'd0);
        check("post_rst_cnt", 32'(cnt[0]), 32'd0);
        check("post_rst_ovld", 32'(out_valid[0]), 32'd0);

        // LEN=8, 8 x 0x0010 back-to-back.
        feed(0, 7, 16'h0010);
        check("a_run_acc7", 32'(acc[0]), 32'h70);
        check("a_run_ovld7", 32'(out_valid[0]), 32'd0);
        feed(0, 1, 16'h0010);
        check("a_ovld", 32'(out_valid[0]), 32'd1);
        check("a_acc", 32'(acc[0]), 32'h80);
        check("a_cnt", 32'(cnt[0]), 32'd8);
        check("a_in_ready", 32'(in_ready[0]), 32'd0);
        release_result(0);
        check("a_clr_ovld", 32'(out_valid[0]), 32'd0);
        check("a_clr_acc", 32'(acc[0]), 32'd0);

        // LEN=8, 8 x 0xFFFF, consumer stalls 5 cycles while producer pushes.
        feed(0, 8, 16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, 16'h1111, 1'b1);
            check("b_hold_acc", 32'(acc[0]), 32'h07FFF8);
            check("b_hold_cnt", 32'(cnt[0]), 32'd8);
            check("b_hold_ovld", 32'(out_valid[0]), 32'd1);
            check("b_hold_in_ready", 32'(in_ready[0]), 32'd0);
            step();
        end
        idle(0);
        check("b_hold_acc_end", 32'(acc[0]), 32'h07FFF8);
        release_result(0);
        check("b_clr_ovld", 32'(out_valid[0]), 32'd0);
        check("b_clr_in_ready", 32'(in_ready[0]), 32'd1);
        check("b_clr_acc", 32'(acc[0]), 32'd0);
        check("b_clr_cnt", 32'(cnt[0]), 32'd0);

        // Early flush coinciding with the third accept.
        feed(0, 1, 16'h0001);
        feed(0, 1, 16'h0002);
        drive(0, 1'b1, 16'h0003, 1'b1);
        step();
        idle(0);
        check("c_ovld", 32'(out_valid[0]), 32'd1);
        check("c_acc", 32'(acc[0]), 32'h6);
        check("c_cnt", 32'(cnt[0]), 32'd3);
        release_result(0);
        drive(0, 1'b0, 16'h0000, 1'b1);
        step();
        check("c_empty_flush_ovld", 32'(out_valid[0]), 32'd0);
        step();
        idle(0);
        check("c_empty_flush_ovld2", 32'(out_valid[0]), 32'd0);
        check("c_empty_flush_cnt", 32'(cnt[0]), 32'd0);
        // Flush after a counted product with no accept that cycle closes the run.
        feed(0, 1, 16'h0005);
        drive(0, 1'b0, 16'h0000, 1'b1);
        step();
        idle(0);
        check("c_late_flush_ovld", 32'(out_valid[0]), 32'd1);
        check("c_late_flush_acc", 32'(acc[0]), 32'h5);
        release_result(0);

        // LEN=4, accepts on cycles 0,3,4,9 of 0x0100.
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 3 || c == 4 || c == 9) drive(1, 1'b1, 16'h0100, 1'b0);
            else idle(1);
            step();
            if (c == 4) check("d_cnt_mid", 32'(cnt[1]), 32'd3);
            if (c == 8) check("d_ovld_mid", 32'(out_valid[1]), 32'd0);
        end
        idle(1);
        check("d_ovld", 32'(out_valid[1]), 32'd1);
        check("d_acc", 32'(acc[1]), 32'h400);
        check("d_cnt", 32'(cnt[1]), 32'd4);

        // LEN=1: every accept closes a result; zero product still counts.
        feed(2, 1, 16'h1234);
        check("f_ovld", 32'(out_valid[2]), 32'd1);
        check("f_acc", 32'(acc[2]), 32'h1234);
        check("f_cnt", 32'(cnt[2]), 32'd1);
        release_result(2);
        feed(2, 1, 16'h0000);
        check("f_zero_ovld", 32'(out_valid[2]), 32'd1);
        check("f_zero_acc", 32'(acc[2]), 32'd0);
        check("f_zero_cnt", 32'(cnt[2]), 32'd1);

        // LEN=256 full-scale sum.
        feed(3, 255, 16'hFFFF);
        check("g_cnt255", 32'(cnt[3]), 32'd255);
        check("g_ovld255", 32'(out_valid[3]), 32'd0);
        feed(3, 1, 16'hFFFF);
        check("g_ovld", 32'(out_valid[3]), 32'd1);
        check("g_acc", 32'(acc[3]), 32'hFFFF00);
        check("g_cnt", 32'(cnt[3]), 32'd256);

        // Asynchronous reset between edges after 5 accepts.
        feed(0, 5, 16'h0010);
        check("e_pre_cnt", 32'(cnt[0]), 32'd5);
        #3 rst = 1'b1;
        #1;
        check("e_rst_acc", 32'(acc[0]), 32'd0);
        check("e_rst_cnt", 32'(cnt[0]), 32'd0);
        check("e_rst_ovld", 32'(out_valid[0]), 32'd0);
        check("e_rst_in_ready", 32'(in_ready[0]), 32'd0);
        check("e_rst_ovld_len4", 32'(out_valid[1]), 32'd0);
        #1 rst = 1'b0;
        step();
        feed(0, 8, 16'h0002);
        check("e_acc", 32'(acc[0]), 32'h10);
        check("e_cnt", 32'(cnt[0]), 32'd8);
        check("e_ovld", 32'(out_valid[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter: LEN, default 8, number of products per accumulation, legal range 1..256.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset. One clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: prod  input  16  unsigned product word from the 8x8 approximate multiplier output (prod8).
REQ-005 SHALL have port: in_valid  input  1  prod is valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  block accepts prod this cycle.
REQ-007 SHALL have port: flush  input  1  close current accumulation early.
REQ-008 SHALL have port: acc  output  24  registered accumulated sum.
REQ-009 SHALL have port: cnt  output  9  number of products contained in acc.
REQ-010 SHALL have port: out_valid  output  1  acc/cnt hold a completed result.
REQ-011 SHALL have port: out_ready  input  1  consumer takes result this cycle.

Function
REQ-012 SHALL accept a product only on a cycle with in_valid=1 and in_ready=1 (accept).
REQ-013 SHALL implement two states: ACC (collecting, in_ready=1, out_valid=0) and HOLD (result presented, in_ready=0, out_valid=1).
REQ-014 SHALL, in ACC, on accept add zero-extended prod to the running sum and increment the product counter.
REQ-015 SHALL arithmetic: 24-bit unsigned sum, no saturation or wrap needed (256 x 0xFFFF = 0xFFFF00 fits).
REQ-016 SHALL transition ACC->HOLD on the cycle the LEN-th product is accepted; acc/cnt/out_valid valid the next cycle (latency 1 cycle from final accept).
REQ-017 SHALL transition ACC->HOLD on flush=1 when counter>0 or an accept occurs the same cycle; a product accepted with flush is included in the result.
REQ-018 SHALL ignore flush in ACC when counter=0 and no accept occurs (no empty result, cnt=0 never output).
REQ-019 SHALL ignore flush in HOLD.
REQ-020 SHALL hold acc, cnt, out_valid stable in HOLD while out_ready=0.
REQ-021 SHALL, in HOLD with out_ready=1, return to ACC next cycle with running sum and counter cleared; in_ready=1 from that cycle (one-cycle bubble between results).
REQ-022 SHALL, with LEN=1, go to HOLD after every single accept.
REQ-023 SHALL keep acc and cnt showing running sum/count in ACC (out_valid=0 qualifies them as non-final).
REQ-024 SHALL treat prod=0 as a normal product (counted, sum unchanged).

Reset
REQ-025 SHALL, on rst=1 (asynchronous), force state ACC, acc=0, cnt=0, out_valid=0, in_ready=1 after reset release.
REQ-026 SHALL, on rst mid-accumulation or in HOLD, discard partial sum and pending result; no output handshake completes.
REQ-027 SHALL keep in_ready=0 while rst=1.

Verification
REQ-028 SHALL verify: LEN=8, 8 back-to-back accepts of 0x0010 -> one cycle after 8th accept out_valid=1, acc=0x000080, cnt=8.
REQ-029 SHALL verify: LEN=8, 8 accepts of 0xFFFF, out_ready=0 for 5 cycles -> acc=0x07FFF8, cnt=8 held stable, in_ready=0 throughout; out_ready=1 -> next cycle out_valid=0, in_ready=1, acc=0.
REQ-030 SHALL verify: 3 accepts (0x0001,0x0002,0x0003), flush on 3rd accept -> acc=0x000006, cnt=3; flush on a later cycle with no accept after clear -> ignored, out_valid stays 0.
REQ-031 SHALL verify: in_valid toggling with gaps (accepts on cycles 0,3,4,9 of 0x0100 each, LEN=4) -> acc=0x000400, cnt=4, out_valid one cycle after cycle 9.
REQ-032 SHALL verify: rst pulse between clock edges after 5 accepts -> acc=0, cnt=0, out_valid=0 immediately; next 8 accepts of 0x0002 -> acc=0x000010.
REQ-033 SHALL verify: LEN=256, 256 accepts of 0xFFFF -> acc=0xFFFF00, cnt=256, no overflow.
